readout_tally: RTL and testbench
================================

# readout_tally

Per-run shot statistics accumulator placed directly downstream of `classify`. It takes each classified 2-bit qubit state and tallies it over a programmed number of shots: ground, excited and ambiguous outcomes. When the run completes it signals with a one-cycle `done` pulse. The host/UART path reads the held counts afterwards to compute state populations.

## Interface
Parameters:
- `COUNT_W`, 16, width of shot target and all counters.

Ports:
- `clk100`, input, 1, system clock. All logic is on the rising edge.
- `rst`, input, 1, reset. Synchronous, active-high.
- `start`, input, 1, one-cycle pulse that begins a run. Sampled only in IDLE.
- `num_shots`, input, COUNT_W, shots per run. Latched on an accepted `start`.
- `state_valid`, input, 1, one-cycle strobe that qualifies `state`.
- `state`, input, 2, `classify` output. 2'b00 = |0>, 2'b01 = |1>, 2'b10 or 2'b11 = ambiguous.
- `count0`, output, COUNT_W, number of |0> shots in the current/last run.
- `count1`, output, COUNT_W, number of |1> shots.
- `count_amb`, output, COUNT_W, number of ambiguous shots.
- `shots_done`, output, COUNT_W, total valid shots accepted in the run.
- `flips`, output, COUNT_W, consecutive-shot state changes (see Configuration).
- `busy`, output, 1, high while in RUN.
- `done`, output, 1, one-cycle completion pulse.

## Operation
- FSM states are IDLE, RUN and FIN.
- IDLE:
  - Counters hold the last run's results.
  - `state_valid` is ignored.
  - `start`=1: clear all counters, latch `num_shots` into `target`, go to RUN.
  - If the latched `target`==0, go to FIN instead.
- RUN, on each `state_valid`:
  - Increment `shots_done`.
  - Increment exactly one of `count0`, `count1` or `count_amb` according to `state`.
  - If `shots_done`+1 == `target`, go to FIN on the same edge.
- FIN: assert `done` for one cycle, then go to IDLE unconditionally.
- `start` in RUN or FIN is ignored. There is no restart mid-run.
- `start` and `state_valid` in the same IDLE cycle: the start is accepted, the strobe is discarded, counters clear.
- Invariant: `count0`+`count1`+`count_amb` == `shots_done` at every cycle.
- Overflow cannot occur, because `shots_done` ≤ `target` ≤ 2^COUNT_W−1. No saturation logic is needed.
- `num_shots` may change freely after `start` has been accepted. It has no effect until the next run.
- `rst` in any state:
  - All counters = 0, `target` = 0.
  - FSM = IDLE, `busy` = 0, `done` = 0.
  - Any in-progress run is discarded with no `done` pulse.

## Timing
- Reset values: all count outputs 0, `busy` 0, `done` 0.
- Latency from `state_valid` at edge N to updated counts: visible after edge N (registered, one cycle).
- Final shot accepted at edge N:
  - Counts are final after edge N.
  - `done`=1 during cycle N+1, `busy`=0 from N+1.
  - IDLE is reached at N+2.
- `start` at edge S:
  - `busy`=1 and counters=0 from S.
  - The first shot can be accepted at edge S+1.
- `target`==0: `done` is high in cycle S+1, with all counts 0.
- `state_valid` may arrive on back-to-back cycles. Every strobe in RUN is counted, up to `target`.
- Strobes arriving in FIN are dropped.

## Configuration
- Macro `READOUT_TALLY_FLIPS_EN`.
- Defined:
  - A 2-bit `prev_state` register plus a `have_prev` flag, both cleared on `start` and `rst`.
  - On each accepted shot with `have_prev`=1 and `state`≠`prev_state` (raw 2-bit compare), `flips` increments.
  - `prev_state` updates on every accepted shot.
  - The first shot of a run never counts as a flip.
- Not defined: `flips` is constant 0 and no extra registers are built.

## Test plan
- Reset/idle: assert `rst`, then strobe `state`=01 three times with no `start` -> all counts 0, `busy`=0, no `done`.
- Basic run: `num_shots`=5, then states 00,01,01,10,00 on non-adjacent cycles -> `count0`=2, `count1`=2, `count_amb`=1, `shots_done`=5, one `done` pulse the cycle after the 5th strobe.
- Back-to-back and excess strobes: `num_shots`=3, six consecutive-cycle strobes of 01 -> `count1`=3, `shots_done`=3, strobes 4–6 ignored.
- Zero shots and ignored start: `num_shots`=0 -> `done` at S+1 with zero counts. Separately, a second `start` mid-run with `num_shots`=10 -> the original target of 4 still ends the run.
- Reset mid-run: `num_shots`=8, two shots, then `rst` -> all counts 0, no `done`. A new `start` with `num_shots`=1 then completes normally.
- Flips (macro defined): states 00,01,01,00,11 with `num_shots`=5 -> `flips`=3. Same run with the macro undefined -> `flips`=0.

Source files
------------

// File: rtl/readout_tally.sv
// -----------------------------------------------------------------------------
// readout_tally
//
// Per-run shot statistics accumulator that sits after the state classifier.
// Each run counts a programmed number of classified shots. Every shot is
// sorted into one of three buckets: ground (|0>), excited (|1>) or ambiguous.
// When the run finishes, a one-cycle done pulse is emitted. The counts then
// hold until the next run starts, so the host can read them afterwards.
//
// Optional feature: define READOUT_TALLY_FLIPS_EN to count state changes
// between consecutive shots on the flips output. When it is not defined,
// flips is tied to zero and no extra registers are built.
//
// Parameters:
//   COUNT_W      width of the shot target and of every counter
// Ports:
//   clk100       system clock, all logic on the rising edge
//   rst          synchronous active-high reset
//   start        one-cycle run start, honoured only while idle
//   num_shots    shots per run, latched when start is accepted
//   state_valid  strobe qualifying state
//   state        classifier output: 00=|0>, 01=|1>, 1x=ambiguous
//   count0       |0> shots in the current/last run
//   count1       |1> shots in the current/last run
//   count_amb    ambiguous shots in the current/last run
//   shots_done   total shots accepted in the current/last run
//   flips        consecutive-shot state changes (0 unless feature enabled)
//   busy         high while a run is collecting shots
//   done         one-cycle completion pulse
// -----------------------------------------------------------------------------
module readout_tally #(
  parameter int COUNT_W = 16
) (
  input  logic               clk100,
  input  logic               rst,
  input  logic               start,
  input  logic [COUNT_W-1:0] num_shots,
  input  logic               state_valid,
  input  logic [1:0]         state,
  output logic [COUNT_W-1:0] count0,
  output logic [COUNT_W-1:0] count1,
  output logic [COUNT_W-1:0] count_amb,
  output logic [COUNT_W-1:0] shots_done,
  output logic [COUNT_W-1:0] flips,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } fsm_t;

  fsm_t               r_fsm;
  logic [COUNT_W-1:0] r_target;
  logic [COUNT_W-1:0] r_count0;
  logic [COUNT_W-1:0] r_count1;
  logic [COUNT_W-1:0] r_count_amb;
  logic [COUNT_W-1:0] r_shots_done;
  logic               r_busy;
  logic               r_done;

  logic w_start_acc;
  logic w_shot_acc;
  logic w_last_shot;

  assign w_start_acc = (r_fsm == S_IDLE) && start;
  assign w_shot_acc  = (r_fsm == S_RUN) && state_valid;
  // shots_done is always below target while in RUN, so the +1 cannot wrap.
  assign w_last_shot = (r_shots_done + 1'b1) == r_target;

  always_ff @(posedge clk100) begin
    if (rst) begin
      r_fsm        <= S_IDLE;
      r_target     <= '0;
      r_count0     <= '0;
      r_count1     <= '0;
      r_count_amb  <= '0;
      r_shots_done <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          r_done <= 1'b0;
          // A strobe arriving with start is dropped: the counters clear instead.
          if (start) begin
            r_target     <= num_shots;
            r_count0     <= '0;
            r_count1     <= '0;
            r_count_amb  <= '0;
            r_shots_done <= '0;
            if (num_shots == '0) begin
              // An empty run completes immediately without ever being busy.
              r_fsm  <= S_FIN;
              r_done <= 1'b1;
              r_busy <= 1'b0;
            end else begin
              r_fsm  <= S_RUN;
              r_busy <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (state_valid) begin
            r_shots_done <= r_shots_done + 1'b1;
            case (state)
              2'b00:   r_count0    <= r_count0 + 1'b1;
              2'b01:   r_count1    <= r_count1 + 1'b1;
              default: r_count_amb <= r_count_amb + 1'b1;
            endcase
            // done is registered on entry to FIN, so it is high for exactly
            // the single cycle spent in FIN.
            if (w_last_shot) begin
              r_fsm  <= S_FIN;
              r_busy <= 1'b0;
              r_done <= 1'b1;
            end
          end
        end
        S_FIN: begin
          r_fsm  <= S_IDLE;
          r_done <= 1'b0;
        end
        default: begin
          r_fsm  <= S_IDLE;
          r_busy <= 1'b0;
          r_done <= 1'b0;
        end
      endcase
    end
  end

`ifdef READOUT_TALLY_FLIPS_EN
  logic [1:0]         r_prev_state;
  logic               r_have_prev;
  logic [COUNT_W-1:0] r_flips;

  always_ff @(posedge clk100) begin
    if (rst || w_start_acc) begin
      r_prev_state <= 2'b00;
      r_have_prev  <= 1'b0;
      r_flips      <= '0;
    end else if (w_shot_acc) begin
      // Raw 2-bit compare: 10 -> 11 counts as a flip even though both are
      // ambiguous.
      if (r_have_prev && (state != r_prev_state))
        r_flips <= r_flips + 1'b1;
      r_prev_state <= state;
      r_have_prev  <= 1'b1;
    end
  end

  assign flips = r_flips;
`else
  assign flips = '0;
`endif

  assign count0     = r_count0;
  assign count1     = r_count1;
  assign count_amb  = r_count_amb;
  assign shots_done = r_shots_done;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_readout_tally.sv
// -----------------------------------------------------------------------------
// tb_readout_tally
//
// Directed bench for readout_tally. It drives inputs just after each rising
// edge and samples outputs 1 ns after the edge. Every expected value is
// written out by hand.
// -----------------------------------------------------------------------------
module tb_readout_tally;

  localparam int COUNT_W = 16;

`ifdef READOUT_TALLY_FLIPS_EN
  localparam int FLIPS_EXP = 3;
`else
  localparam int FLIPS_EXP = 0;
`endif

  logic               clk100;
  logic               rst;
  logic               start;
  logic [COUNT_W-1:0] num_shots;
  logic               state_valid;
  logic [1:0]         state;
  logic [COUNT_W-1:0] count0;
  logic [COUNT_W-1:0] count1;
  logic [COUNT_W-1:0] count_amb;
  logic [COUNT_W-1:0] shots_done;
  logic [COUNT_W-1:0] flips;
  logic               busy;
  logic               done;

  int total;
  int bad;

  readout_tally #(.COUNT_W(COUNT_W)) dut (
    .clk100      (clk100),
    .rst         (rst),
    .start       (start),
    .num_shots   (num_shots),
    .state_valid (state_valid),
    .state       (state),
    .count0      (count0),
    .count1      (count1),
    .count_amb   (count_amb),
    .shots_done  (shots_done),
    .flips       (flips),
    .busy        (busy),
    .done        (done)
  );

  initial clk100 = 1'b0;
  always #5 clk100 = ~clk100;

  task automatic tick();
    @(posedge clk100);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] req);
    total++;
    assert (act === req) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, act, req);
    end
  endtask

  task automatic chk_counts(input string tag, input int c0, input int c1,
                            input int ca, input int sd);
    chk({tag, ".count0"},     32'(count0),     32'(c0));
    chk({tag, ".count1"},     32'(count1),     32'(c1));
    chk({tag, ".count_amb"},  32'(count_amb),  32'(ca));
    chk({tag, ".shots_done"}, 32'(shots_done), 32'(sd));
  endtask

  task automatic do_start(input int n);
    num_shots = COUNT_W'(n);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // One strobed shot followed by an idle cycle. Sampling happens after the
  // strobe edge, before the gap.
  task automatic shot(input logic [1:0] s);
    state_valid = 1'b1;
    state       = s;
    tick();
    state_valid = 1'b0;
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst         = 1'b1;
    start       = 1'b0;
    num_shots   = '0;
    state_valid = 1'b0;
    state       = 2'b00;

    // Reset state, then strobes in IDLE without start are ignored.
    tick();
    tick();
    rst = 1'b0;
    chk_counts("reset", 0, 0, 0, 0);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.done", 32'(done), 32'd0);
    for (int i = 0; i < 3; i++) begin
      shot(2'b01);
      chk("idle_strobe.done", 32'(done), 32'd0);
    end
    chk_counts("idle_strobe", 0, 0, 0, 0);
    chk("idle_strobe.busy", 32'(busy), 32'd0);

    // Basic run: 00,01,01,10,00 on non-adjacent cycles.
    do_start(5);
    chk("basic.busy_at_start", 32'(busy), 32'd1);
    chk_counts("basic.start", 0, 0, 0, 0);
    shot(2'b00); tick();
    chk_counts("basic.first", 1, 0, 0, 1);
    shot(2'b01); tick();
    shot(2'b01); tick();
    shot(2'b10);
    chk("basic.done_early", 32'(done), 32'd0);
    tick();
    shot(2'b00);
    chk("basic.done", 32'(done), 32'd1);
    chk("basic.busy_fin", 32'(busy), 32'd0);
    chk_counts("basic.final", 2, 2, 1, 5);
    tick();
    chk("basic.done_pulse_end", 32'(done), 32'd0);
    tick();
    chk_counts("basic.hold", 2, 2, 1, 5);

    // Back-to-back strobes beyond the target: only three count.
    do_start(3);
    state_valid = 1'b1;
    state       = 2'b01;
    tick();
    tick();
    chk("b2b.done_early", 32'(done), 32'd0);
    tick();
    chk("b2b.done", 32'(done), 32'd1);
    chk_counts("b2b.at_done", 0, 3, 0, 3);
    tick();
    chk("b2b.done_end", 32'(done), 32'd0);
    tick();
    tick();
    state_valid = 1'b0;
    chk_counts("b2b.excess", 0, 3, 0, 3);
    chk("b2b.busy", 32'(busy), 32'd0);

    // Zero-shot run finishes at once with cleared counts.
    do_start(0);
    chk("zero.done", 32'(done), 32'd1);
    chk("zero.busy", 32'(busy), 32'd0);
    chk_counts("zero", 0, 0, 0, 0);
    tick();
    chk("zero.done_end", 32'(done), 32'd0);
    tick();

    // Start mid-run is ignored; the original target of 4 ends the run.
    do_start(4);
    shot(2'b00); tick();
    num_shots = 16'd10;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    chk("restart.no_clear", 32'(shots_done), 32'd1);
    chk("restart.busy", 32'(busy), 32'd1);
    shot(2'b01); tick();
    shot(2'b01);
    chk("restart.done_early", 32'(done), 32'd0);
    tick();
    shot(2'b10);
    chk("restart.done", 32'(done), 32'd1);
    chk_counts("restart.final", 1, 2, 1, 4);
    tick();
    tick();

    // Start with a coincident strobe: the strobe is discarded.
    num_shots   = 16'd2;
    start       = 1'b1;
    state_valid = 1'b1;
    state       = 2'b00;
    tick();
    start       = 1'b0;
    state_valid = 1'b0;
    chk_counts("start_strobe", 0, 0, 0, 0);
    chk("start_strobe.busy", 32'(busy), 32'd1);

    // Reset mid-run discards the run with no done pulse.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    do_start(8);
    shot(2'b00); tick();
    shot(2'b10); tick();
    chk_counts("midrst.before", 1, 0, 1, 2);
    rst = 1'b1;
    tick();
    chk_counts("midrst.after", 0, 0, 0, 0);
    chk("midrst.busy", 32'(busy), 32'd0);
    chk("midrst.done", 32'(done), 32'd0);
    rst = 1'b0;
    tick();
    chk("midrst.no_done", 32'(done), 32'd0);
    do_start(1);
    shot(2'b01);
    chk("postrst.done", 32'(done), 32'd1);
    chk_counts("postrst", 0, 1, 0, 1);
    tick();
    tick();

    // Flip counting: 00,01,01,00,11 gives three changes when enabled.
    do_start(5);
    shot(2'b00); tick();
    chk("flips.first", 32'(flips), 32'd0);
    shot(2'b01); tick();
    shot(2'b01); tick();
    shot(2'b00); tick();
    shot(2'b11);
    chk("flips.done", 32'(done), 32'd1);
    chk_counts("flips.counts", 2, 2, 1, 5);
    chk("flips.value", 32'(flips), 32'(FLIPS_EXP));
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
